// File: rtl/pixel_format_converter_if.sv
// Pixel-path bundle between the camera source and the formatter: 24-bit pixel in,
// 16-bit converted pixel plus line/tail status out.
interface pixel_format_converter_if #(
    parameter int IDX_W = 9
);
    logic             wFgPixelValid;
    logic [23:0]      wConvPixel;
    logic             wFgOutValid;
    logic [15:0]      wOutPixel;
    logic             wFgLineEnd;
    logic [IDX_W-1:0] wPixIdx;
    logic             wFgInTail;
    logic             wFgOverrun;

    modport master (
        output wFgPixelValid, wConvPixel,
        input  wFgOutValid, wOutPixel, wFgLineEnd, wPixIdx, wFgInTail, wFgOverrun
    );

    modport slave (
        input  wFgPixelValid, wConvPixel,
        output wFgOutValid, wOutPixel, wFgLineEnd, wPixIdx, wFgInTail, wFgOverrun
    );
endinterface

// File: rtl/pixel_format_converter.sv
// RGB888 to 16-bit formatter with a two-stage enable-gated pipeline, per-line pixel
// counting and a post-line blanking tail that drops and flags late pixels.
module pixel_format_converter #(
    parameter int LINE_PIXELS = 480,
    parameter int TAIL_TICKS  = 2,
    parameter int IDX_W       = $clog2(LINE_PIXELS)
) (
    input  logic       iClk,
    input  logic       wRsn,
    input  logic       wEnClk,
    input  logic       wStCnn,
    input  logic [1:0] iMode,
    pixel_format_converter_if.slave pix
);
    localparam int TAIL_W = (TAIL_TICKS < 1) ? 1 : $clog2(TAIL_TICKS + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_PIXELS - 1);
    localparam logic [TAIL_W-1:0] TAIL_LOAD = TAIL_W'(TAIL_TICKS);

    function automatic logic [15:0] convert_pixel(input logic [1:0] mode, input logic [23:0] px);
        logic [7:0]  r, g, b, y;
        logic [5:0]  r_rnd, b_rnd;
        logic [6:0]  g_rnd;
        logic [4:0]  r5, b5;
        logic [5:0]  g6;
        logic [15:0] y_sum;
        r = px[23:16];
        g = px[15:8];
        b = px[7:0];
        r_rnd = 6'(({1'b0, r} + 9'd4) >> 3);
        g_rnd = 7'(({1'b0, g} + 9'd2) >> 2);
        b_rnd = 6'(({1'b0, b} + 9'd4) >> 3);
        r5 = r_rnd[5] ? 5'd31 : r_rnd[4:0];
        g6 = g_rnd[6] ? 6'd63 : g_rnd[5:0];
        b5 = b_rnd[5] ? 5'd31 : b_rnd[4:0];
        // Luma weights sum to 256, so the 16-bit sum never exceeds 0xFF80.
        y_sum = 16'd77 * {8'd0, r} + 16'd150 * {8'd0, g} + 16'd29 * {8'd0, b} + 16'd128;
        y = 8'(y_sum >> 8);
        case (mode)
            2'b00:   convert_pixel = {r[7:3], g[7:2], b[7:3]};
            2'b01:   convert_pixel = {r5, g6, b5};
            2'b10:   convert_pixel = {1'b0, r[7:3], g[7:3], b[7:3]};
            2'b11:   convert_pixel = {y[7:3], y[7:2], y[7:3]};
            default: convert_pixel = 16'h0000;
        endcase
    endfunction

    logic [1:0]        mode_r, mode_s;
    logic [IDX_W-1:0]  line_cnt_r, line_cnt_s;
    logic [TAIL_W-1:0] tail_r, tail_s;
    logic [23:0]       s1_pix_r, s1_pix_s;
    logic              s1_valid_r, s1_valid_s;
    logic [IDX_W-1:0]  s1_idx_r, s1_idx_s;
    logic              s1_last_r, s1_last_s;
    logic [15:0]       out_pixel_r, out_pixel_s;
    logic              out_valid_r, out_valid_s;
    logic              line_end_r, line_end_s;
    logic [IDX_W-1:0]  pix_idx_r, pix_idx_s;
    logic              in_tail_r, in_tail_s;
    logic              overrun_r, overrun_s;
    logic              tail_active_s, accept_s, at_last_s;

    // Next-state for mode, counters and both pipeline stages.
    always_comb begin
        tail_active_s = (tail_r != '0);
        accept_s      = wEnClk & pix.wFgPixelValid & ~tail_active_s;
        at_last_s     = (line_cnt_r == LAST_IDX);
        mode_s        = mode_r;
        line_cnt_s    = line_cnt_r;
        tail_s        = tail_r;
        s1_pix_s      = s1_pix_r;
        s1_valid_s    = s1_valid_r;
        s1_idx_s      = s1_idx_r;
        s1_last_s     = s1_last_r;
        out_pixel_s   = out_pixel_r;
        out_valid_s   = out_valid_r;
        line_end_s    = line_end_r;
        pix_idx_s     = pix_idx_r;
        overrun_s     = overrun_r;
        if (wStCnn) begin
            // Frame start wins over any simultaneous accept; that pixel vanishes silently.
            mode_s      = iMode;
            line_cnt_s  = '0;
            tail_s      = '0;
            s1_valid_s  = 1'b0;
            s1_last_s   = 1'b0;
            out_valid_s = 1'b0;
            line_end_s  = 1'b0;
            overrun_s   = 1'b0;
        end else if (wEnClk) begin
            s1_pix_s    = pix.wConvPixel;
            s1_valid_s  = accept_s;
            s1_idx_s    = line_cnt_r;
            s1_last_s   = accept_s & at_last_s;
            out_valid_s = s1_valid_r;
            line_end_s  = s1_last_r;
            if (s1_valid_r) begin
                out_pixel_s = convert_pixel(mode_r, s1_pix_r);
                pix_idx_s   = s1_idx_r;
            end else begin
                out_pixel_s = out_pixel_r;
                pix_idx_s   = pix_idx_r;
            end
            if (accept_s) begin
                if (at_last_s) begin
                    line_cnt_s = '0;
                    tail_s     = TAIL_LOAD;
                end else begin
                    line_cnt_s = line_cnt_r + IDX_W'(1);
                    tail_s     = tail_r;
                end
            end else if (tail_active_s) begin
                tail_s = tail_r - TAIL_W'(1);
                if (pix.wFgPixelValid) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_r;
                end
            end else begin
                tail_s = tail_r;
            end
        end else begin
            mode_s = mode_r;
        end
        in_tail_s = (tail_s != '0);
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge iClk or negedge wRsn) begin
        if (!wRsn) begin
            mode_r      <= 2'b00;
            line_cnt_r  <= '0;
            tail_r      <= '0;
            s1_pix_r    <= 24'h000000;
            s1_valid_r  <= 1'b0;
            s1_idx_r    <= '0;
            s1_last_r   <= 1'b0;
            out_pixel_r <= 16'h0000;
            out_valid_r <= 1'b0;
            line_end_r  <= 1'b0;
            pix_idx_r   <= '0;
            in_tail_r   <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            mode_r      <= mode_s;
            line_cnt_r  <= line_cnt_s;
            tail_r      <= tail_s;
            s1_pix_r    <= s1_pix_s;
            s1_valid_r  <= s1_valid_s;
            s1_idx_r    <= s1_idx_s;
            s1_last_r   <= s1_last_s;
            out_pixel_r <= out_pixel_s;
            out_valid_r <= out_valid_s;
            line_end_r  <= line_end_s;
            pix_idx_r   <= pix_idx_s;
            in_tail_r   <= in_tail_s;
            overrun_r   <= overrun_s;
        end
    end

    assign pix.wFgOutValid = out_valid_r;
    assign pix.wOutPixel   = out_pixel_r;
    assign pix.wFgLineEnd  = line_end_r;
    assign pix.wPixIdx     = pix_idx_r;
    assign pix.wFgInTail   = in_tail_r;
    assign pix.wFgOverrun  = overrun_r;
endmodule

// File: tb/tb_pixel_format_converter.sv
// Directed bench for pixel_format_converter with a 4-pixel line and a 2-tick tail.
module tb_pixel_format_converter;
    logic       iClk = 1'b0;
    logic       wRsn;
    logic       wEnClk;
    logic       wStCnn;
    logic [1:0] iMode;
    int         errors = 0;
    int         checks = 0;

    pixel_format_converter_if #(.IDX_W(2)) bus ();

    pixel_format_converter #(.LINE_PIXELS(4), .TAIL_TICKS(2), .IDX_W(2)) dut (
        .iClk   (iClk),
        .wRsn   (wRsn),
        .wEnClk (wEnClk),
        .wStCnn (wStCnn),
        .iMode  (iMode),
        .pix    (bus.slave)
    );

    always #5 iClk = ~iClk;

    task automatic tick(input int gap);
        wEnClk = 1'b1;
        @(posedge iClk); #1;
        wEnClk = 1'b0;
        repeat (gap) @(posedge iClk);
        #1;
    endtask

    task automatic start(input logic [1:0] m);
        iMode  = m;
        wStCnn = 1'b1;
        @(posedge iClk); #1;
        wStCnn = 1'b0;
    endtask

    task automatic send(input logic [23:0] px);
        bus.wFgPixelValid = 1'b1;
        bus.wConvPixel    = px;
        tick(0);
        bus.wFgPixelValid = 1'b0;
    endtask

    task automatic test_reset;
        #3 wRsn = 1'b0;
        #4;
        checks += 6;
        if (bus.wFgOutValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.wFgOutValid); end
        if (bus.wOutPixel !== 16'h0000) begin errors++; $display("FAIL reset_pixel: got %h want 0000", bus.wOutPixel); end
        if (bus.wFgLineEnd !== 1'b0) begin errors++; $display("FAIL reset_line_end: got %b want 0", bus.wFgLineEnd); end
        if (bus.wPixIdx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus.wPixIdx); end
        if (bus.wFgInTail !== 1'b0) begin errors++; $display("FAIL reset_tail: got %b want 0", bus.wFgInTail); end
        if (bus.wFgOverrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", bus.wFgOverrun); end
        @(negedge iClk) wRsn = 1'b1;
        @(posedge iClk); #1;
    endtask

    task automatic test_mode00;
        start(2'b00);
        send(24'hFF8010);
        checks++;
        if (bus.wFgOutValid !== 1'b0) begin errors++; $display("FAIL m00_latency: valid got %b want 0", bus.wFgOutValid); end
        tick(0);
        checks += 3;
        if (bus.wFgOutValid !== 1'b1) begin errors++; $display("FAIL m00_valid: got %b want 1", bus.wFgOutValid); end
        if (bus.wOutPixel !== 16'hFC02) begin errors++; $display("FAIL m00_pixel: got %h want fc02", bus.wOutPixel); end
        if (bus.wPixIdx !== 2'd0) begin errors++; $display("FAIL m00_idx: got %0d want 0", bus.wPixIdx); end
        @(posedge iClk); #1;
        checks++;
        if (bus.wFgOutValid !== 1'b1) begin errors++; $display("FAIL m00_hold: valid got %b want 1", bus.wFgOutValid); end
    endtask

    task automatic test_back_to_back;
        start(2'b01);
        send(24'hFEFF04);
        send(24'h0CFF04);
        checks += 2;
        if (bus.wOutPixel !== 16'hFFE1) begin errors++; $display("FAIL m01_sat: got %h want ffe1", bus.wOutPixel); end
        if (bus.wPixIdx !== 2'd0) begin errors++; $display("FAIL m01_idx0: got %0d want 0", bus.wPixIdx); end
        tick(0);
        checks += 3;
        if (bus.wOutPixel !== 16'h17E1) begin errors++; $display("FAIL m01_round: got %h want 17e1", bus.wOutPixel); end
        if (bus.wPixIdx !== 2'd1) begin errors++; $display("FAIL m01_idx1: got %0d want 1", bus.wPixIdx); end
        if (bus.wFgOutValid !== 1'b1) begin errors++; $display("FAIL m01_valid: got %b want 1", bus.wFgOutValid); end
    endtask

    task automatic test_gray_555;
        start(2'b11);
        send(24'hFFFFFF);
        send(24'h000000);
        checks++;
        if (bus.wOutPixel !== 16'hFFFF) begin errors++; $display("FAIL gray_white: got %h want ffff", bus.wOutPixel); end
        send(24'h808080);
        checks++;
        if (bus.wOutPixel !== 16'h0000) begin errors++; $display("FAIL gray_black: got %h want 0000", bus.wOutPixel); end
        tick(0);
        checks++;
        if (bus.wOutPixel !== 16'h8410) begin errors++; $display("FAIL gray_mid: got %h want 8410", bus.wOutPixel); end
        start(2'b10);
        send(24'hFFFFFF);
        tick(0);
        checks++;
        if (bus.wOutPixel !== 16'h7FFF) begin errors++; $display("FAIL rgb555_white: got %h want 7fff", bus.wOutPixel); end
    endtask

    task automatic test_line_tail;
        int ev [0:7] = '{0, 1, 1, 1, 1, 0, 0, 1};
        int ei [0:7] = '{0, 0, 1, 2, 3, 0, 0, 0};
        int el [0:7] = '{0, 0, 0, 0, 1, 0, 0, 0};
        int et [0:7] = '{0, 0, 0, 1, 1, 0, 0, 0};
        int eo [0:7] = '{0, 0, 0, 0, 1, 1, 1, 1};
        start(2'b00);
        for (int t = 1; t <= 8; t++) begin
            bus.wFgPixelValid = 1'b1;
            bus.wConvPixel    = {t[4:0], 3'b000, 16'h0000};
            tick(3);
            checks += 4;
            if (bus.wFgOutValid !== ev[t-1][0]) begin errors++; $display("FAIL line_valid t%0d: got %b want %0d", t, bus.wFgOutValid, ev[t-1]); end
            if (bus.wFgLineEnd !== el[t-1][0]) begin errors++; $display("FAIL line_end t%0d: got %b want %0d", t, bus.wFgLineEnd, el[t-1]); end
            if (bus.wFgInTail !== et[t-1][0]) begin errors++; $display("FAIL line_tail t%0d: got %b want %0d", t, bus.wFgInTail, et[t-1]); end
            if (bus.wFgOverrun !== eo[t-1][0]) begin errors++; $display("FAIL line_overrun t%0d: got %b want %0d", t, bus.wFgOverrun, eo[t-1]); end
            if (ev[t-1] == 1) begin
                checks++;
                if (bus.wPixIdx !== ei[t-1][1:0]) begin errors++; $display("FAIL line_idx t%0d: got %0d want %0d", t, bus.wPixIdx, ei[t-1]); end
            end
        end
        bus.wFgPixelValid = 1'b0;
        checks++;
        if (bus.wOutPixel !== 16'h3800) begin errors++; $display("FAIL line_pixel: got %h want 3800", bus.wOutPixel); end
    endtask

    task automatic test_mode_change;
        iMode = 2'b01;
        send(24'hFEFF04);
        tick(0);
        checks += 3;
        if (bus.wOutPixel !== 16'hFFE0) begin errors++; $display("FAIL mode_hold: got %h want ffe0", bus.wOutPixel); end
        if (bus.wPixIdx !== 2'd2) begin errors++; $display("FAIL mode_hold_idx: got %0d want 2", bus.wPixIdx); end
        if (bus.wFgOutValid !== 1'b1) begin errors++; $display("FAIL mode_hold_valid: got %b want 1", bus.wFgOutValid); end
        bus.wFgPixelValid = 1'b1;
        wEnClk = 1'b1;
        start(2'b01);
        wEnClk = 1'b0;
        bus.wFgPixelValid = 1'b0;
        checks += 3;
        if (bus.wFgOutValid !== 1'b0) begin errors++; $display("FAIL st_valid: got %b want 0", bus.wFgOutValid); end
        if (bus.wFgOverrun !== 1'b0) begin errors++; $display("FAIL st_overrun: got %b want 0", bus.wFgOverrun); end
        if (bus.wFgInTail !== 1'b0) begin errors++; $display("FAIL st_tail: got %b want 0", bus.wFgInTail); end
        send(24'hFEFF04);
        tick(0);
        checks += 3;
        if (bus.wOutPixel !== 16'hFFE1) begin errors++; $display("FAIL st_new_mode: got %h want ffe1", bus.wOutPixel); end
        if (bus.wPixIdx !== 2'd0) begin errors++; $display("FAIL st_idx: got %0d want 0", bus.wPixIdx); end
        if (bus.wFgOverrun !== 1'b0) begin errors++; $display("FAIL st_no_flag: got %b want 0", bus.wFgOverrun); end
    endtask

    task automatic test_async_reset;
        start(2'b01);
        send(24'h123456);
        send(24'h654321);
        send(24'hABCDEF);
        #2 wRsn = 1'b0;
        #1;
        checks += 4;
        if (bus.wFgOutValid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", bus.wFgOutValid); end
        if (bus.wOutPixel !== 16'h0000) begin errors++; $display("FAIL arst_pixel: got %h want 0000", bus.wOutPixel); end
        if (bus.wPixIdx !== 2'd0) begin errors++; $display("FAIL arst_idx: got %0d want 0", bus.wPixIdx); end
        if (bus.wFgLineEnd !== 1'b0) begin errors++; $display("FAIL arst_line_end: got %b want 0", bus.wFgLineEnd); end
        @(negedge iClk) wRsn = 1'b1;
        @(posedge iClk); #1;
        send(24'hFEFF04);
        tick(0);
        checks += 3;
        if (bus.wFgOutValid !== 1'b1) begin errors++; $display("FAIL arst_after_valid: got %b want 1", bus.wFgOutValid); end
        if (bus.wOutPixel !== 16'hFFE0) begin errors++; $display("FAIL arst_mode00: got %h want ffe0", bus.wOutPixel); end
        if (bus.wPixIdx !== 2'd0) begin errors++; $display("FAIL arst_after_idx: got %0d want 0", bus.wPixIdx); end
    endtask

    initial begin
        wRsn = 1'b1;
        wEnClk = 1'b0;
        wStCnn = 1'b0;
        iMode = 2'b00;
        bus.wFgPixelValid = 1'b0;
        bus.wConvPixel = 24'h000000;
        test_reset();
        test_mode00();
        test_back_to_back();
        test_gray_555();
        test_line_tail();
        test_mode_change();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
